// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one add-and-shift step per clock, WIDTH steps, Done pulse after the last step.
// Optional two's-complement mode compiled in with macro SEQ_MULTIPLIER_SIGNED_EN (Signed port ignored otherwise).
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  mplier_q;
    logic              busy_q;
    logic              done_q;

    logic              ext_a;
    logic              ext_m;
    logic              sub;
    logic [WIDTH:0]    a_ext;
    logic [WIDTH:0]    m_ext;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  mplier_d;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic              signed_q;
`else
    logic              unused_signed;
    assign unused_signed = Signed;
`endif

    // The product lives in {acc, mplier}; the multiplier bits shift out as product bits shift in.
    always_comb begin
        ext_a = 1'b0;
        ext_m = 1'b0;
        sub   = 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        ext_a = signed_q & acc_q[WIDTH-1];
        ext_m = signed_q & mcand_q[WIDTH-1];
        sub   = signed_q & (cnt_q == LAST);
`endif
        a_ext = {ext_a, acc_q};
        m_ext = {ext_m, mcand_q};
        sum   = a_ext;
        if (mplier_q[0]) begin
            sum = sub ? (a_ext - m_ext) : (a_ext + m_ext);
        end
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        mcand_q  <= Multiplicando;
                        acc_q    <= '0;
                        mplier_q <= Multiplicador;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                        signed_q <= Signed;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Produto = {acc_q, mplier_q};
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized scoreboard bench for seq_multiplier: expected products and Done cycles are queued at issue,
// a negedge monitor pops and compares on every Done pulse.
module tb_seq_multiplier;

    localparam int W = 16;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic             Signed;
    logic [W-1:0]     Multiplicando;
    logic [W-1:0]     Multiplicador;
    logic [2*W-1:0]   Produto;
    logic             Busy;
    logic             Done;

    seq_multiplier #(.WIDTH(W)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Signed        (Signed),
        .Multiplicando (Multiplicando),
        .Multiplicador (Multiplicador),
        .Produto       (Produto),
        .Busy          (Busy),
        .Done          (Done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    int             cyc_q[$];
    int             last_load = -1000;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        longint pa;
        longint pb;
        pa = longint'(a);
        pb = longint'(b);
        if (sgn && SIGNED_EN) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end
        return (2*W)'(pa * pb);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation in value and cycle.
    always @(negedge Clk) begin
        if (!Reset && Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: Done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                check("produto", longint'(Produto), longint'(exp_q.pop_front()));
                check("done_cycle", longint'(cyc), longint'(cyc_q.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        while (cyc < last_load + W) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Presents an operation for one edge, then scrambles inputs to prove they were latched.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit expect_done);
        Multiplicando = a;
        Multiplicador = b;
        Signed        = s;
        Start         = 1'b1;
        @(posedge Clk);
        #1;
        last_load     = cyc;
        Start         = 1'b0;
        Multiplicando = W'($urandom);
        Multiplicador = W'($urandom);
        Signed        = 1'($urandom);
        if (expect_done) begin
            exp_q.push_back(model(a, b, s));
            cyc_q.push_back(cyc + W);
        end
    endtask

    initial begin
        int nbusy;
        int ndone;
        int k;
        Reset = 1'b1;
        Start = 1'b0;
        Signed = 1'b0;
        Multiplicando = '0;
        Multiplicador = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_produto", longint'(Produto), 0);
        check("reset_busy", longint'(Busy), 0);
        check("reset_done", longint'(Done), 0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Basic 3 x 5, Busy must be high for exactly W cycles.
        issue(16'd3, 16'd5, 1'b0, 1'b1);
        nbusy = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge Clk);
            if (Busy) nbusy++;
            if (Done) break;
        end
        check("busy_cycles", longint'(nbusy), longint'(W));
        @(posedge Clk);
        #1;

        wait_ready();
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_ready();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_ready();
        issue(16'h8000, 16'h8000, 1'b1, 1'b1);
        wait_ready();
        issue(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_ready();
        issue(16'h0001, 16'h8000, 1'b1, 1'b1);

        // Start pulse during RUN is ignored.
        wait_ready();
        issue(16'h1234, 16'h00AB, 1'b0, 1'b1);
        repeat (4) @(posedge Clk);
        #1;
        Multiplicando = 16'h5555;
        Multiplicador = 16'h7777;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;

        // Back-to-back: Start held through RUN and DONE, operands changed to 7 x 9 mid-run.
        wait_ready();
        Multiplicando = 16'hABCD;
        Multiplicador = 16'h0102;
        Signed = 1'b0;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        k = cyc;
        last_load = k;
        exp_q.push_back(model(16'hABCD, 16'h0102, 1'b0));
        cyc_q.push_back(k + W);
        Multiplicando = 16'd7;
        Multiplicador = 16'd9;
        repeat (W + 1) @(posedge Clk);
        #1;
        Start = 1'b0;
        last_load = k + W + 1;
        exp_q.push_back(model(16'd7, 16'd9, 1'b0));
        cyc_q.push_back(k + 2 * W + 1);

        // Abort by reset at edge 8 of a run: nothing queued, no Done allowed.
        wait_ready();
        issue(16'h4321, 16'h0F0F, 1'b0, 1'b0);
        repeat (7) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("abort_produto", longint'(Produto), 0);
        check("abort_busy", longint'(Busy), 0);
        check("abort_done", longint'(Done), 0);
        ndone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge Clk);
            if (Done) ndone++;
        end
        check("abort_no_done", longint'(ndone), 0);
        @(posedge Clk);
        #1;
        last_load = -1000;

        // First operation after reset, then randomized traffic with random gaps.
        issue(16'd100, 16'd200, 1'b0, 1'b1);
        for (int n = 0; n < 24; n++) begin
            wait_ready();
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        for (int i = 0; i < 4 * W && exp_q.size() != 0; i++) @(posedge Clk);
        @(negedge Clk);
        check("pending_results", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
